// File: rtl/pc_fetch_unit_pkg.sv
// Shared processor package: fetch state encodings, address width and the
// instruction value presented by an empty/reset IF/ID slot.
package pc_fetch_unit_pkg;

    localparam int PC_WIDTH = 32;

    // Instruction value held in the IF/ID slot out of reset
    localparam logic [PC_WIDTH-1:0] RESET_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request may be issued this cycle
        ST_WAIT  = 2'd1,   // one request outstanding
        ST_HOLD  = 2'd2    // slot and skid both full, fetch stalled
    } fetch_state_e;

    // Branch/jump targets are forced onto a word boundary
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_adder.sv
// Sequential program-counter incrementer. Wraps modulo 2^PC_WIDTH.
module pc_adder
    import pc_fetch_unit_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_inc
);

    localparam logic [PC_WIDTH-1:0] STEP_W = PC_WIDTH'(STEP);

    assign pc_inc = pc + STEP_W;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, returns the
// fetched instruction through a single IF/ID slot backed by a one-entry skid
// buffer, and handles redirects, including dropping a stale in-flight reply.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int                  PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [PC_WIDTH-1:0] imem_rdata,
    output logic                if_valid,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [PC_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0] if_pc_next,
    input  logic                id_ready
);

    fetch_state_e        state_r,      state_s;
    logic [PC_WIDTH-1:0] pc_r,         pc_s;
    logic                if_valid_r,   if_valid_s;
    logic [PC_WIDTH-1:0] if_pc_r,      if_pc_s;
    logic [PC_WIDTH-1:0] if_instr_r,   if_instr_s;
    logic [PC_WIDTH-1:0] if_pc_next_r, if_pc_next_s;
    logic [PC_WIDTH-1:0] skid_pc_r,    skid_pc_s;
    logic [PC_WIDTH-1:0] skid_instr_r, skid_instr_s;
    logic                discard_r,    discard_s;
    logic                req_en_r;     // low until the first edge after reset release
    logic [PC_WIDTH-1:0] pc_plus_s;
    logic                imem_req_s;

    pc_adder #(
        .STEP   (PC_STEP)
    ) u_pc_adder (
        .pc     (pc_r),
        .pc_inc (pc_plus_s)
    );

    assign imem_req_s = (state_r == ST_FETCH) & ~redirect_valid & req_en_r;
    assign imem_req   = imem_req_s;
    assign imem_addr  = pc_r;
    assign if_valid   = if_valid_r;
    assign if_pc      = if_pc_r;
    assign if_instr   = if_instr_r;
    assign if_pc_next = if_pc_next_r;

    // Next-state and next-slot logic; a redirect overrides everything else
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        if_valid_s   = if_valid_r & ~id_ready;   // decode consumes the slot
        if_pc_s      = if_pc_r;
        if_instr_s   = if_instr_r;
        if_pc_next_s = if_pc_next_r;
        skid_pc_s    = skid_pc_r;
        skid_instr_s = skid_instr_r;
        discard_s    = discard_r;

        if (redirect_valid) begin
            pc_s         = align_pc(redirect_pc);
            if_valid_s   = 1'b0;
            skid_pc_s    = {PC_WIDTH{1'b0}};
            skid_instr_s = RESET_INSTR;
            if ((state_r == ST_WAIT) && !imem_rvalid) begin
                // reply still in flight: remember to drop it
                state_s   = ST_WAIT;
                discard_s = 1'b1;
            end else begin
                state_s   = ST_FETCH;
                discard_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_req_s && imem_ready) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (!imem_rvalid) begin
                        state_s = ST_WAIT;
                    end else if (discard_r) begin
                        discard_s = 1'b0;
                        state_s   = ST_FETCH;
                    end else if (!if_valid_r || id_ready) begin
                        if_valid_s   = 1'b1;
                        if_pc_s      = pc_r;
                        if_instr_s   = imem_rdata;
                        if_pc_next_s = pc_plus_s;
                        pc_s         = pc_plus_s;
                        state_s      = ST_FETCH;
                    end else begin
                        skid_pc_s    = pc_r;
                        skid_instr_s = imem_rdata;
                        pc_s         = pc_plus_s;
                        state_s      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (id_ready) begin
                        // pc already advanced past the skid entry, so it is
                        // exactly that entry's sequential successor
                        if_valid_s   = 1'b1;
                        if_pc_s      = skid_pc_r;
                        if_instr_s   = skid_instr_r;
                        if_pc_next_s = pc_r;
                        state_s      = ST_FETCH;
                    end else begin
                        if_valid_s   = 1'b1;
                        state_s      = ST_HOLD;
                    end
                end
                default: begin
                    state_s    = ST_FETCH;
                    if_valid_s = 1'b0;
                    discard_s  = 1'b0;
                end
            endcase
        end
    end

    // Fetch state registers; reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            if_valid_r   <= 1'b0;
            if_pc_r      <= {PC_WIDTH{1'b0}};
            if_instr_r   <= RESET_INSTR;
            if_pc_next_r <= {PC_WIDTH{1'b0}};
            skid_pc_r    <= {PC_WIDTH{1'b0}};
            skid_instr_r <= RESET_INSTR;
            discard_r    <= 1'b0;
            req_en_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            if_valid_r   <= if_valid_s;
            if_pc_r      <= if_pc_s;
            if_instr_r   <= if_instr_s;
            if_pc_next_r <= if_pc_next_s;
            skid_pc_r    <= skid_pc_s;
            skid_instr_r <= skid_instr_s;
            discard_r    <= discard_s;
            req_en_r     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic checked
// against a transaction-level model (queue of held instructions).
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_next;
    logic        id_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model: held instructions (front = IF/ID slot), fetch pointer,
    // request in flight, stale-reply flag, request-enable after reset.
    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_discard;
    bit          m_run;

    pc_fetch_unit #(
        .RESET_PC (RST_PC),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_next     (if_pc_next),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_pc      = RST_PC;
        m_out     = 1'b0;
        m_discard = 1'b0;
        m_run     = 1'b0;
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0000_0000;
        id_ready       = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, then let the DUT take the edge
    task automatic tick();
        bit   req;
        ent_t e;
        req = m_run && !m_out && (m_q.size() < 2) && !redirect_valid;
        if (redirect_valid) begin
            m_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_out && !imem_rvalid) begin
                m_discard = 1'b1;
            end else begin
                m_out     = 1'b0;
                m_discard = 1'b0;
            end
        end else begin
            if (id_ready && (m_q.size() > 0)) void'(m_q.pop_front());
            if (m_out && imem_rvalid) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                end else begin
                    e.pc    = m_pc;
                    e.instr = imem_rdata;
                    m_q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
                m_out = 1'b0;
            end else if (req && imem_ready) begin
                m_out = 1'b1;
            end
        end
        m_run = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        #3;
        total++; if (if_valid !== 1'b0)  begin bad++; $display("FAIL rst_if_valid got=%0b exp=0", if_valid); end
        total++; if (if_pc !== 32'h0)     begin bad++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
        total++; if (if_instr !== 32'h0)  begin bad++; $display("FAIL rst_if_instr got=%h exp=0", if_instr); end
        total++; if (if_pc_next !== 32'h0) begin bad++; $display("FAIL rst_if_pc_next got=%h exp=0", if_pc_next); end
        total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RST_PC); end
        total++; if (imem_req !== 1'b0)   begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
        // memory activity during reset must be ignored
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        @(posedge clk);
        #1;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_ignore_rvalid got=%0b exp=0", if_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req_hold got=%0b exp=0", imem_req); end
        idle_inputs();
        #2;
        rst_n = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req_pre_edge got=%0b exp=0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b1)   begin bad++; $display("FAIL rst_req_rise got=%0b exp=1", imem_req); end
        total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_first_addr got=%h exp=%h", imem_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        logic [31:0] d;
        pulse_reset();
        id_ready   = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 4 * i;
            d = 32'h1000_0000 + i;
            imem_rvalid = 1'b0;
            #1;
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL seq_req[%0d] got=%0b exp=1", i, imem_req); end
            total++; if (imem_addr !== a)   begin bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr, a); end
            tick();
            imem_rvalid = 1'b1;
            imem_rdata  = d;
            tick();
            imem_rvalid = 1'b0;
            #1;
            total++; if (if_valid !== 1'b1)     begin bad++; $display("FAIL seq_valid[%0d] got=%0b exp=1", i, if_valid); end
            total++; if (if_pc !== a)           begin bad++; $display("FAIL seq_if_pc[%0d] got=%h exp=%h", i, if_pc, a); end
            total++; if (if_instr !== d)        begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, if_instr, d); end
            total++; if (if_pc_next !== a + 32'd4) begin bad++; $display("FAIL seq_pc_next[%0d] got=%h exp=%h", i, if_pc_next, a + 32'd4); end
        end
        idle_inputs();
    endtask

    task automatic test_skid();
        pulse_reset();
        id_ready   = 1'b0;
        imem_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_000A;
        tick();
        imem_rvalid = 1'b0;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_000B;
        tick();
        imem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (imem_req !== 1'b0)     begin bad++; $display("FAIL skid_hold_req[%0d] got=%0b exp=0", k, imem_req); end
            total++; if (if_instr !== 32'hA)    begin bad++; $display("FAIL skid_hold_instr[%0d] got=%h exp=a", k, if_instr); end
            total++; if (if_pc !== 32'h0)       begin bad++; $display("FAIL skid_hold_pc[%0d] got=%h exp=0", k, if_pc); end
            total++; if (if_valid !== 1'b1)     begin bad++; $display("FAIL skid_hold_valid[%0d] got=%0b exp=1", k, if_valid); end
            tick();
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        total++; if (if_instr !== 32'hB)    begin bad++; $display("FAIL skid_out_instr got=%h exp=b", if_instr); end
        total++; if (if_pc !== 32'h4)       begin bad++; $display("FAIL skid_out_pc got=%h exp=4", if_pc); end
        total++; if (if_pc_next !== 32'h8)  begin bad++; $display("FAIL skid_out_pc_next got=%h exp=8", if_pc_next); end
        total++; if (imem_req !== 1'b1)     begin bad++; $display("FAIL skid_out_req got=%0b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h8)   begin bad++; $display("FAIL skid_out_addr got=%h exp=8", imem_addr); end
        idle_inputs();
    endtask

    task automatic test_redirect_wait();
        pulse_reset();
        imem_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0077;
        tick();
        imem_rvalid = 1'b0;
        tick();
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdw_req_during got=%0b exp=0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rdw_addr got=%h exp=100", imem_addr); end
        total++; if (if_valid !== 1'b0)     begin bad++; $display("FAIL rdw_valid_cleared got=%0b exp=0", if_valid); end
        total++; if (imem_req !== 1'b0)     begin bad++; $display("FAIL rdw_req_wait got=%0b exp=0", imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        #1;
        total++; if (if_valid !== 1'b0)     begin bad++; $display("FAIL rdw_dropped got=%0b exp=0", if_valid); end
        total++; if (imem_req !== 1'b1)     begin bad++; $display("FAIL rdw_req_after got=%0b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rdw_addr_after got=%h exp=100", imem_addr); end
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_00C0;
        tick();
        imem_rvalid = 1'b0;
        #1;
        total++; if (if_valid !== 1'b1)      begin bad++; $display("FAIL rdw_new_valid got=%0b exp=1", if_valid); end
        total++; if (if_pc !== 32'h100)      begin bad++; $display("FAIL rdw_new_pc got=%h exp=100", if_pc); end
        total++; if (if_instr !== 32'hC0)    begin bad++; $display("FAIL rdw_new_instr got=%h exp=c0", if_instr); end
        idle_inputs();
    endtask

    task automatic test_redirect_rvalid();
        pulse_reset();
        imem_ready = 1'b1;
        tick();
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h0000_00EE;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        total++; if (if_valid !== 1'b0)     begin bad++; $display("FAIL rdr_no_load got=%0b exp=0", if_valid); end
        total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL rdr_addr got=%h exp=200", imem_addr); end
        total++; if (imem_req !== 1'b1)     begin bad++; $display("FAIL rdr_req got=%0b exp=1", imem_req); end
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_00FF;
        tick();
        imem_rvalid = 1'b0;
        #1;
        total++; if (if_valid !== 1'b1)   begin bad++; $display("FAIL rdr_next_valid got=%0b exp=1", if_valid); end
        total++; if (if_pc !== 32'h200)   begin bad++; $display("FAIL rdr_next_pc got=%h exp=200", if_pc); end
        total++; if (if_instr !== 32'hFF) begin bad++; $display("FAIL rdr_next_instr got=%h exp=ff", if_instr); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        pulse_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_5A5A;
        tick();
        imem_rvalid = 1'b0;
        #1;
        total++; if (if_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_if_pc got=%h exp=fffffffc", if_pc); end
        total++; if (if_pc_next !== 32'h0)    begin bad++; $display("FAIL wrap_pc_next got=%h exp=0", if_pc_next); end
        total++; if (imem_addr !== 32'h0)     begin bad++; $display("FAIL wrap_next_addr got=%h exp=0", imem_addr); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        pulse_reset();
        imem_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0011;
        tick();
        imem_rvalid = 1'b0;
        tick();
        imem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (if_valid !== 1'b0)     begin bad++; $display("FAIL rmw_valid got=%0b exp=0", if_valid); end
        total++; if (if_pc !== 32'h0)       begin bad++; $display("FAIL rmw_if_pc got=%h exp=0", if_pc); end
        total++; if (if_instr !== 32'h0)    begin bad++; $display("FAIL rmw_instr got=%h exp=0", if_instr); end
        total++; if (if_pc_next !== 32'h0)  begin bad++; $display("FAIL rmw_pc_next got=%h exp=0", if_pc_next); end
        total++; if (imem_addr !== RST_PC)  begin bad++; $display("FAIL rmw_addr got=%h exp=%h", imem_addr, RST_PC); end
        total++; if (imem_req !== 1'b0)     begin bad++; $display("FAIL rmw_req got=%0b exp=0", imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(posedge clk);
        #3;
        imem_rvalid = 1'b0;
        rst_n       = 1'b1;
        tick();
        #1;
        total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rmw_restart_addr got=%h exp=%h", imem_addr, RST_PC); end
        total++; if (imem_req !== 1'b1)    begin bad++; $display("FAIL rmw_restart_req got=%0b exp=1", imem_req); end
        total++; if (if_valid !== 1'b0)    begin bad++; $display("FAIL rmw_restart_valid got=%0b exp=0", if_valid); end
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0022;
        tick();
        imem_rvalid = 1'b0;
        #1;
        total++; if (if_pc !== RST_PC)    begin bad++; $display("FAIL rmw_first_pc got=%h exp=%h", if_pc, RST_PC); end
        total++; if (if_instr !== 32'h22) begin bad++; $display("FAIL rmw_first_instr got=%h exp=22", if_instr); end
        idle_inputs();
    endtask

    task automatic test_random();
        bit          exp_req;
        logic [31:0] exp_next;
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            end else begin
                redirect_pc = $urandom;
            end
            imem_ready  = $urandom_range(0, 1);
            imem_rvalid = m_out && ($urandom_range(0, 2) != 0);
            imem_rdata  = $urandom;
            id_ready    = $urandom_range(0, 1);
            #1;
            exp_req = m_run && !m_out && (m_q.size() < 2) && !redirect_valid;
            total++; if (imem_req !== exp_req) begin bad++; $display("FAIL rnd_req[%0d] got=%0b exp=%0b", i, imem_req, exp_req); end
            total++; if (imem_addr !== m_pc)   begin bad++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, imem_addr, m_pc); end
            total++; if (if_valid !== (m_q.size() > 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", i, if_valid, (m_q.size() > 0)); end
            if (m_q.size() > 0) begin
                exp_next = m_q[0].pc + 32'd4;
                total++; if (if_pc !== m_q[0].pc)       begin bad++; $display("FAIL rnd_if_pc[%0d] got=%h exp=%h", i, if_pc, m_q[0].pc); end
                total++; if (if_instr !== m_q[0].instr) begin bad++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", i, if_instr, m_q[0].instr); end
                total++; if (if_pc_next !== exp_next)   begin bad++; $display("FAIL rnd_pc_next[%0d] got=%h exp=%h", i, if_pc_next, exp_next); end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_skid();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, the sequential increment passed to the pc_adder instance.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have the following ports:
- redirect_valid  in  1  branch/jump taken, highest priority
- redirect_pc  in  32  branch/jump target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equal to pc
- imem_ready  in  1  request accepted this cycle
- imem_rvalid  in  1  instruction returned
- imem_rdata  in  32  returned instruction
- if_valid  out  1  IF/ID slot holds an instruction
- if_pc  out  32  address of the held instruction
- if_instr  out  32  held instruction
- if_pc_next  out  32  if_pc + PC_STEP
- id_ready  in  1  decode consumes the slot this cycle when if_valid=1

Function
REQ-005 SHALL implement states FETCH, WAIT and HOLD, with at most one outstanding memory request.
REQ-006 SHALL drive imem_req = (state==FETCH) & ~redirect_valid, and imem_addr = pc at all times.
REQ-007 In FETCH, imem_req & imem_ready SHALL move the block to WAIT; otherwise it SHALL stay in FETCH with pc held.
REQ-008 In WAIT, imem_rvalid with the slot free (if_valid=0, or id_ready=1) SHALL do all of the following in the same edge: load {pc, imem_rdata, pc+PC_STEP} into the slot, set if_valid=1, set pc <= pc+PC_STEP, and move to FETCH.
REQ-009 In WAIT, imem_rvalid with the slot full and id_ready=0 SHALL capture {pc, imem_rdata} into a one-entry skid buffer, advance pc, and move to HOLD.
REQ-010 In HOLD, imem_req SHALL be 0; on id_ready=1 the skid entry SHALL move into the slot and the block SHALL return to FETCH.
REQ-011 id_ready=1 with if_valid=1 and no refill on the same edge SHALL clear if_valid.
REQ-012 redirect_valid in any state SHALL, on that edge, set pc <= {redirect_pc[31:2],2'b00}, clear if_valid, and empty the skid buffer.
REQ-013 After a redirect, the state SHALL be FETCH unless the request is still outstanding.
REQ-014 A redirect in WAIT without same-cycle imem_rvalid SHALL set a discard flag and remain in WAIT.
REQ-015 The next imem_rvalid while the discard flag is set SHALL be dropped, SHALL clear the flag, and SHALL return the block to FETCH.
REQ-016 A redirect coincident with imem_rvalid SHALL drop that response with no discard flag set.
REQ-017 pc SHALL wrap modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error flag.
REQ-018 if_pc, if_instr and if_pc_next SHALL hold their values while if_valid=1 and id_ready=0.

Reset
REQ-019 Asserting rst_n=0 SHALL immediately force the following, independent of clk:
- pc=RESET_PC
- state=FETCH
- if_valid=0, if_pc=0, if_instr=0, if_pc_next=0
- skid buffer empty, discard flag=0
REQ-020 imem_req SHALL be 0 while rst_n=0 and SHALL rise on the first clk edge region after deassertion, with imem_addr=RESET_PC.
REQ-021 Reset asserted mid-WAIT SHALL abandon the outstanding request; responses arriving during reset SHALL be ignored.

Structure
REQ-022 State encodings, PC_WIDTH=32 and the NOP/reset instruction constant SHALL reside in the shared processor package.
REQ-023 The sequential increment SHALL use one instance of the existing pc_adder sub-module; no other sub-module SHALL be used.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset release, imem_ready=1, rvalid one cycle after each grant, id_ready=1 -> imem_addr 0,4,8; if_pc 0,4,8 with if_valid=1.
- id_ready=0 for 3 cycles with rdata 32'hA, then 32'hB -> if_instr holds A, skid holds B, imem_req=0 in HOLD; id_ready=1 -> if_instr=B, next fetch address=8.
- Redirect to 32'h0000_0103 during WAIT -> response dropped, next imem_addr=32'h0000_0100, if_valid=0 until the new rvalid.
- Redirect coincident with imem_rvalid -> no slot load, next imem_addr equals the target.
- pc=32'hFFFF_FFFC fetched -> if_pc_next=0, next imem_addr=0.
- rst_n pulsed low mid-WAIT -> outputs reset asynchronously, next imem_addr=RESET_PC.
